// File: rtl/rf_wport_if.sv
// Bundle of the register-file write-port arbiter signals: writeback request,
// multi-cycle request/ready, pipeline stall, clear status and the rf write port.
interface rf_wport_if #(
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned D_WIDTH = 32
);
  logic               wb_we;
  logic [A_WIDTH-1:0] wb_ad;
  logic [D_WIDTH-1:0] wb_wd;
  logic               mc_valid;
  logic [A_WIDTH-1:0] mc_ad;
  logic [D_WIDTH-1:0] mc_wd;
  logic               mc_ready;
  logic               stall_wb;
  logic               clear_busy;
  logic               rf_we3;
  logic [A_WIDTH-1:0] rf_ad3;
  logic [D_WIDTH-1:0] rf_wd3;

  // Requesters and rf side.
  modport master (
    output wb_we, wb_ad, wb_wd, mc_valid, mc_ad, mc_wd,
    input  mc_ready, stall_wb, clear_busy, rf_we3, rf_ad3, rf_wd3
  );

  // Arbiter side.
  modport slave (
    input  wb_we, wb_ad, wb_wd, mc_valid, mc_ad, mc_wd,
    output mc_ready, stall_wb, clear_busy, rf_we3, rf_ad3, rf_wd3
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. Writeback normally wins; a multi-cycle
// requester refused STARVE_MAX cycles in a row forces writeback to stall once.
// Optional feature macro RF_CLEAR_EN: after reset, zero x1..x(2**A_WIDTH-1)
// through the write port before any request is accepted.
module rf_wport_arbiter #(
  parameter int unsigned A_WIDTH    = 5,
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic        clk,
  input logic        rst_n,
  rf_wport_if.slave  bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic               in_run;
  logic [A_WIDTH-1:0] clr_ad;
  logic               wb_req;
  logic               force_mc;
  logic               stall_wb;
  logic               mc_ready;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               rf_we3_q, rf_we3_d;
  logic [A_WIDTH-1:0] rf_ad3_q, rf_ad3_d;
  logic [D_WIDTH-1:0] rf_wd3_q, rf_wd3_d;

`ifdef RF_CLEAR_EN
  typedef enum logic {StClear, StRun} state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] clr_idx_q, clr_idx_d;

  // Walk clr_idx over every non-zero register, then hand the port to RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + A_WIDTH'(1);
      if (clr_idx_q == '1) state_d = StRun;
    end
  end

  // Clear sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_idx_q <= A_WIDTH'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign in_run = (state_q == StRun);
  assign clr_ad = clr_idx_q;
`else
  assign in_run = 1'b1;
  assign clr_ad = '0;
`endif

  // Arbitration, next rf write and starvation counter.
  always_comb begin
    wb_req   = bus.wb_we && (bus.wb_ad != '0);
    force_mc = bus.mc_valid && (starve_cnt_q == StarveMax);
    // During clear every real writeback request is held off.
    stall_wb = in_run ? (wb_req && force_mc) : wb_req;
    mc_ready = in_run && bus.mc_valid && (!wb_req || force_mc);

    rf_we3_d = 1'b0;
    rf_ad3_d = rf_ad3_q;
    rf_wd3_d = rf_wd3_q;
    if (!in_run) begin
      rf_we3_d = 1'b1;
      rf_ad3_d = clr_ad;
      rf_wd3_d = '0;
    end else if (wb_req && !force_mc) begin
      rf_we3_d = 1'b1;
      rf_ad3_d = bus.wb_ad;
      rf_wd3_d = bus.wb_wd;
    end else if (mc_ready) begin
      // An mc write to x0 is consumed but never reaches the rf.
      rf_we3_d = (bus.mc_ad != '0);
      rf_ad3_d = bus.mc_ad;
      rf_wd3_d = bus.mc_wd;
    end

    starve_cnt_d = starve_cnt_q;
    if (!bus.mc_valid || mc_ready) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Registered rf write port and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we3_q     <= 1'b0;
      rf_ad3_q     <= '0;
      rf_wd3_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      rf_we3_q     <= rf_we3_d;
      rf_ad3_q     <= rf_ad3_d;
      rf_wd3_q     <= rf_wd3_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.mc_ready   = mc_ready;
  assign bus.stall_wb   = stall_wb;
  assign bus.clear_busy = !in_run;
  assign bus.rf_we3     = rf_we3_q;
  assign bus.rf_ad3     = rf_ad3_q;
  assign bus.rf_wd3     = rf_wd3_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: a cycle model checked on every negedge plus
// directed scenarios with literal expectations. Follows RF_CLEAR_EN.
module tb_rf_wport_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;
`ifdef RF_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wport_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  rf_wport_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: clearing flag, next register to clear, refused-mc run length,
  // and what the rf port must show.
  bit          m_clear, p_clear;
  int          m_next, p_next;
  int          m_starve, p_starve;
  bit          m_we, p_we;
  int          m_ad, p_ad;
  logic [31:0] m_wd, p_wd;
  bit          wbr, frc, e_stall, e_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_clear = ClrEn; m_next = 1; m_starve = 0; m_we = 0; m_ad = 0; m_wd = '0;
    end
    wbr = bus.wb_we && (bus.wb_ad != 0);
    frc = bus.mc_valid && (m_starve == SM);
    if (m_clear) begin
      e_stall = wbr;
      e_rdy   = 1'b0;
    end else begin
      e_stall = wbr && frc;
      e_rdy   = bus.mc_valid && (!wbr || frc);
    end
    check("m_stall_wb", bus.stall_wb, e_stall);
    check("m_mc_ready", bus.mc_ready, e_rdy);
    check("m_clear_busy", bus.clear_busy, m_clear);
    check("m_rf_we3", bus.rf_we3, m_we);
    check("m_rf_ad3", bus.rf_ad3, m_ad);
    check("m_rf_wd3", bus.rf_wd3, m_wd);

    p_clear = m_clear; p_next = m_next; p_we = 0; p_ad = m_ad; p_wd = m_wd;
    if (m_clear) begin
      p_we = 1; p_ad = m_next; p_wd = '0;
      if (m_next == (1 << AW) - 1) p_clear = 0;
      p_next = m_next + 1;
    end else if (wbr && !frc) begin
      p_we = 1; p_ad = bus.wb_ad; p_wd = bus.wb_wd;
    end else if (e_rdy) begin
      p_we = (bus.mc_ad != 0); p_ad = bus.mc_ad; p_wd = bus.mc_wd;
    end
    if (!bus.mc_valid || e_rdy) p_starve = 0;
    else p_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
    if (!rst_n) begin
      p_clear = ClrEn; p_next = 1; p_starve = 0; p_we = 0; p_ad = 0; p_wd = '0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_clear = p_clear; m_next = p_next; m_starve = p_starve;
      m_we = p_we; m_ad = p_ad; m_wd = p_wd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.wb_we = we; bus.wb_ad = ad; bus.wb_wd = wd;
  endtask

  task automatic set_mc(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.mc_valid = v; bus.mc_ad = ad; bus.mc_wd = wd;
  endtask

  initial begin
    set_wb(1'b1, 5'd5, 32'h55);
    set_mc(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_we3", bus.rf_we3, 0);
    check("rst_ad3", bus.rf_ad3, 0);
    check("rst_wd3", bus.rf_wd3, 0);
    check("rst_busy", bus.clear_busy, ClrEn);
    check("rst_stall", bus.stall_wb, ClrEn);
    check("rst_ready", bus.mc_ready, 0);
    rst_n = 1'b1;

`ifdef RF_CLEAR_EN
    for (int k = 1; k <= 31; k++) begin
      check("clr_stall", bus.stall_wb, 1);
      step();
      check("clr_we3", bus.rf_we3, 1);
      check("clr_ad3", bus.rf_ad3, k);
      check("clr_wd3", bus.rf_wd3, 0);
    end
    check("clr_done_busy", bus.clear_busy, 0);
    check("clr_done_stall", bus.stall_wb, 0);
`endif
    step();
    check("first_wb_we3", bus.rf_we3, 1);
    check("first_wb_ad3", bus.rf_ad3, 5);
    check("first_wb_wd3", bus.rf_wd3, 32'h55);

    bus.wb_we = 1'b0;
    step();
    check("idle_we3", bus.rf_we3, 0);
    check("idle_ad3_hold", bus.rf_ad3, 5);

    // Plain priority: wb beats mc, mc goes once wb drops.
    set_wb(1'b1, 5'd3, 32'hAAAA_0001);
    set_mc(1'b1, 5'd4, 32'h1234);
    #1;
    check("prio_ready", bus.mc_ready, 0);
    check("prio_stall", bus.stall_wb, 0);
    step();
    check("prio_ad3", bus.rf_ad3, 3);
    check("prio_wd3", bus.rf_wd3, 32'hAAAA_0001);
    bus.wb_we = 1'b0;
    #1;
    check("prio_mc_ready", bus.mc_ready, 1);
    step();
    check("prio_mc_we3", bus.rf_we3, 1);
    check("prio_mc_ad3", bus.rf_ad3, 4);
    check("prio_mc_wd3", bus.rf_wd3, 32'h1234);
    set_mc(1'b0, 5'd0, 32'h0);

    // Starvation: four refusals, then a forced mc win, then the held wb.
    set_wb(1'b1, 5'd7, 32'h77);
    set_mc(1'b1, 5'd9, 32'h99);
    repeat (4) begin
      #1;
      check("starve_refused", bus.mc_ready, 0);
      step();
      check("starve_wb_ad3", bus.rf_ad3, 7);
    end
    #1;
    check("force_stall", bus.stall_wb, 1);
    check("force_ready", bus.mc_ready, 1);
    step();
    check("force_ad3", bus.rf_ad3, 9);
    check("force_wd3", bus.rf_wd3, 32'h99);
    set_mc(1'b0, 5'd0, 32'h0);
    #1;
    check("after_force_stall", bus.stall_wb, 0);
    step();
    check("held_wb_ad3", bus.rf_ad3, 7);

    // x0 on both sides: wb is no request, mc is accepted and dropped.
    set_wb(1'b1, 5'd0, 32'h11);
    set_mc(1'b1, 5'd0, 32'hDEAD);
    #1;
    check("x0_stall", bus.stall_wb, 0);
    check("x0_ready", bus.mc_ready, 1);
    step();
    check("x0_we3", bus.rf_we3, 0);
    check("x0_wd3", bus.rf_wd3, 32'hDEAD);
    set_wb(1'b0, 5'd0, 32'h0);
    set_mc(1'b0, 5'd0, 32'h0);
    step();
    check("hold_wd3", bus.rf_wd3, 32'hDEAD);

    // Reset in the middle of activity.
`ifdef RF_CLEAR_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("mid_clr_ad3", bus.rf_ad3, 10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we3", bus.rf_we3, 0);
    check("mid_rst_ad3", bus.rf_ad3, 0);
    check("mid_rst_wd3", bus.rf_wd3, 0);
    check("mid_rst_busy", bus.clear_busy, 1);
    step();
    rst_n = 1'b1;
    step();
    check("restart_ad3", bus.rf_ad3, 1);
    check("restart_we3", bus.rf_we3, 1);
`else
    set_wb(1'b1, 5'd7, 32'h77);
    set_mc(1'b1, 5'd9, 32'h99);
    repeat (4) step();
    check("pre_rst_force", bus.mc_ready, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we3", bus.rf_we3, 0);
    check("mid_rst_ad3", bus.rf_ad3, 0);
    check("mid_rst_wd3", bus.rf_wd3, 0);
    check("mid_rst_ready", bus.mc_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_wb_ad3", bus.rf_ad3, 7);
    check("post_rst_ready", bus.mc_ready, 0);
`endif
    set_wb(1'b0, 5'd0, 32'h0);
    set_mc(1'b0, 5'd0, 32'h0);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
